// File: rtl/conv_window_ctrl.sv
// Sequencer for a KxK line-buffer window chain: accepts raster pixels, drives the shared shift enable and emits window coordinates.
// Optional stride-2 window generation is enabled by defining CONV_WIN_STRIDE2_EN.
module conv_window_ctrl #(
  parameter int IMG_W = 14,
  parameter int IMG_H = 14,
  parameter int K     = 3,
  parameter int CW    = $clog2(IMG_W),
  parameter int RW    = $clog2(IMG_H)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_start,
  input  logic          i_pix_valid,
  output logic          o_pix_ready,
  output logic          o_sb_en,
  output logic          o_win_valid,
  input  logic          i_win_ready,
  output logic [RW-1:0] o_win_row,
  output logic [CW-1:0] o_win_col,
  output logic          o_busy,
  output logic          o_done
);

  localparam logic [RW-1:0] L_ROW_FIRST = RW'(K - 1);
  localparam logic [RW-1:0] L_ROW_LAST  = RW'(IMG_H - 1);
  localparam logic [CW-1:0] L_COL_FIRST = CW'(K - 1);
  localparam logic [CW-1:0] L_COL_LAST  = CW'(IMG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FILL,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_win_valid;
  logic [RW-1:0] r_win_row;
  logic [CW-1:0] r_win_col;
  logic          r_done;

  logic          w_accepting;
  logic          w_pix_ready;
  logic          w_sb_en;
  logic          w_in_window;
  logic          w_gen;
  logic          w_last;
  logic          w_anchor;
  logic [RW-1:0] w_top_row;
  logic [CW-1:0] w_left_col;

  // A pending window blocks shifting unless it is being consumed this cycle.
  assign w_accepting = (r_state == S_FILL) || (r_state == S_STREAM);
  assign w_pix_ready = w_accepting && (!r_win_valid || i_win_ready);
  assign w_sb_en     = i_pix_valid && w_pix_ready;

  assign w_top_row   = r_row - L_ROW_FIRST;
  assign w_left_col  = r_col - L_COL_FIRST;
  assign w_in_window = (r_row >= L_ROW_FIRST) && (r_col >= L_COL_FIRST);
  assign w_last      = (r_row == L_ROW_LAST) && (r_col == L_COL_LAST);
  assign w_anchor    = (r_row == L_ROW_FIRST) && (r_col == L_COL_FIRST);

`ifdef CONV_WIN_STRIDE2_EN
  assign w_gen = w_sb_en && w_in_window && !w_top_row[0] && !w_left_col[0];
`else
  assign w_gen = w_sb_en && w_in_window;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_win_valid <= 1'b0;
      r_win_row   <= '0;
      r_win_col   <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_sb_en) begin
        if (r_col == L_COL_LAST) begin
          r_col <= '0;
          r_row <= r_row + RW'(1);
        end else begin
          r_col <= r_col + CW'(1);
        end
      end

      // A new window replaces a consumed one in the same cycle for full throughput.
      if (w_gen) begin
        r_win_valid <= 1'b1;
        r_win_row   <= w_top_row;
        r_win_col   <= w_left_col;
      end else if (i_win_ready) begin
        r_win_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_state <= S_FILL;
            r_row   <= '0;
            r_col   <= '0;
          end
        end
        S_FILL: begin
          if (w_sb_en && w_last) begin
            r_state <= S_DRAIN;
          end else if (w_sb_en && w_anchor) begin
            r_state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (w_sb_en && w_last) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (!r_win_valid || i_win_ready) begin
            r_state <= S_DONE;
            r_done  <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_pix_ready = w_pix_ready;
  assign o_sb_en     = w_sb_en;
  assign o_win_valid = r_win_valid;
  assign o_win_row   = r_win_row;
  assign o_win_col   = r_win_col;
  assign o_busy      = (r_state != S_IDLE);
  assign o_done      = r_done;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl on a 5x5 image with a 3x3 kernel.
// Honours CONV_WIN_STRIDE2_EN so the same bench covers the stride-2 build.
module tb_conv_window_ctrl;

  localparam int IMG_W = 5;
  localparam int IMG_H = 5;
  localparam int K     = 3;
  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int NPIX  = IMG_W * IMG_H;

`ifdef CONV_WIN_STRIDE2_EN
  localparam int STRIDE = 2;
  localparam int NWIN   = 4;
  int litRow[NWIN] = '{0, 0, 2, 2};
  int litCol[NWIN] = '{0, 2, 0, 2};
`else
  localparam int STRIDE = 1;
  localparam int NWIN   = 9;
  int litRow[NWIN] = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
  int litCol[NWIN] = '{0, 1, 2, 0, 1, 2, 0, 1, 2};
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          pixValid = 1'b1;
  logic          winReady = 1'b1;
  logic          pixReady;
  logic          sbEn;
  logic          winValid;
  logic [RW-1:0] winRow;
  logic [CW-1:0] winCol;
  logic          busy;
  logic          done;

  conv_window_ctrl #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .K(K), .CW(CW), .RW(RW)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_start    (start),
    .i_pix_valid(pixValid),
    .o_pix_ready(pixReady),
    .o_sb_en    (sbEn),
    .o_win_valid(winValid),
    .i_win_ready(winReady),
    .o_win_row  (winRow),
    .o_win_col  (winCol),
    .o_busy     (busy),
    .o_done     (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit checkEn = 1'b0;

  // Reference model: frame phase (0 idle, 1 taking pixels, 2 waiting last window, 3 done) and pixel count.
  int mPhase = 0;
  int mAccepted = 0;
  bit mWinValid = 1'b0;
  int mWinRow = 0;
  int mWinCol = 0;

  int cyc = 0;
  int frameAccepts = 0;
  int firstAcceptCyc = -1;
  int firstWinCyc = -1;
  int doneCyc = -1;
  int doneCount = 0;
  int logRow[$];
  int logCol[$];

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    bit expReady;
    bit acc;
    bit gen;
    int r;
    int c;
    cyc++;
    expReady = (mPhase == 1) && (!mWinValid || winReady);
    if (checkEn) begin
      checkOutput("pix_ready", pixReady, expReady);
      checkOutput("sb_en", sbEn, pixValid && expReady);
      checkOutput("win_valid", winValid, mWinValid);
      checkOutput("win_row", winRow, mWinRow);
      checkOutput("win_col", winCol, mWinCol);
      checkOutput("busy", busy, mPhase != 0);
      checkOutput("done", done, mPhase == 3);
    end
    if (sbEn) begin
      frameAccepts++;
      if (firstAcceptCyc < 0) firstAcceptCyc = cyc;
    end
    if (winValid && firstWinCyc < 0) firstWinCyc = cyc;
    if (winValid && winReady) begin
      logRow.push_back(winRow);
      logCol.push_back(winCol);
    end
    if (done) begin
      doneCount++;
      doneCyc = cyc;
    end

    if (rst) begin
      mPhase = 0; mAccepted = 0; mWinValid = 0; mWinRow = 0; mWinCol = 0;
    end else begin
      acc = (mPhase == 1) && pixValid && expReady;
      gen = 1'b0;
      r = mAccepted / IMG_W;
      c = mAccepted % IMG_W;
      if (acc) begin
        gen = (r >= K - 1) && (c >= K - 1) &&
              ((r - (K - 1)) % STRIDE == 0) && ((c - (K - 1)) % STRIDE == 0);
        mAccepted++;
      end
      case (mPhase)
        0: if (start) begin mPhase = 1; mAccepted = 0; end
        1: if (acc && mAccepted == NPIX) mPhase = 2;
        2: if (!mWinValid || winReady) mPhase = 3;
        default: mPhase = 0;
      endcase
      if (gen) begin
        mWinValid = 1'b1;
        mWinRow = r - (K - 1);
        mWinCol = c - (K - 1);
      end else if (winReady) begin
        mWinValid = 1'b0;
      end
    end
  end

  task automatic clearFrameStats();
    frameAccepts = 0;
    firstAcceptCyc = -1;
    firstWinCyc = -1;
    doneCyc = -1;
    doneCount = 0;
    logRow.delete();
    logCol.delete();
  endtask

  // Window order must match a plain raster walk over all legal top-left corners.
  task automatic checkWindows(input string tag);
    int expR[$];
    int expC[$];
    int n;
    for (int r = 0; r <= IMG_H - K; r += STRIDE)
      for (int c = 0; c <= IMG_W - K; c += STRIDE) begin
        expR.push_back(r);
        expC.push_back(c);
      end
    checkOutput({tag, "_win_count"}, logRow.size(), expR.size());
    n = (logRow.size() < expR.size()) ? logRow.size() : expR.size();
    for (int i = 0; i < n; i++) begin
      checkOutput({tag, "_win_row"}, logRow[i], expR[i]);
      checkOutput({tag, "_win_col"}, logCol[i], expC[i]);
    end
    checkOutput({tag, "_pixels"}, frameAccepts, NPIX);
    checkOutput({tag, "_done_pulses"}, doneCount, 1);
  endtask

  // validMode: 0 continuous, 1 alternating, 2 random. readyMode: 0 always, 1 stall at (1,1), 2 random.
  task automatic applyStimulus(input int validMode, input int readyMode, input int maxCycles);
    int stallLeft = 0;
    bit stallUsed = 1'b0;
    int n = 0;
    clearFrameStats();
    @(posedge clk) #1;
    start = 1'b1;
    pixValid = 1'b0;
    winReady = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    while (doneCount == 0 && n < maxCycles) begin
      case (validMode)
        0: pixValid = 1'b1;
        1: pixValid = (n % 2 == 0);
        default: pixValid = ($urandom_range(0, 3) != 0);
      endcase
      if (readyMode == 1) begin
        if (!stallUsed && winValid && winRow == 1 && winCol == 1) begin
          stallLeft = 4;
          stallUsed = 1'b1;
        end
        winReady = (stallLeft == 0);
      end else if (readyMode == 2) begin
        winReady = ($urandom_range(0, 9) < 7);
        start = busy && ($urandom_range(0, 15) == 0);
      end else begin
        winReady = 1'b1;
      end
      if (stallLeft > 0) begin
        stallLeft--;
        @(negedge clk);
        checkOutput("stall_sb_en", sbEn, 0);
        checkOutput("stall_row", winRow, 1);
        checkOutput("stall_col", winCol, 1);
      end
      @(posedge clk) #1;
      n++;
    end
    start = 1'b0;
    pixValid = 1'b0;
    winReady = 1'b1;
    if (doneCount == 0) checkOutput("frame_timeout", 0, 1);
    if (readyMode == 1) checkOutput("stall_happened", stallUsed, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    pixValid = 1'b1;
    @(posedge clk) #1;
    checkEn = 1'b1;
    @(posedge clk) #1;
    @(negedge clk);
    checkOutput("rst_pix_ready", pixReady, 0);
    checkOutput("rst_win_valid", winValid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    checkOutput("rst_win_row", winRow, 0);
    checkOutput("rst_win_col", winCol, 0);
    @(posedge clk) #1;
    rst = 1'b0;
    pixValid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("idle_no_accept", frameAccepts, 0);

    applyStimulus(0, 0, 200);
    checkWindows("full");
    checkOutput("full_first_win_latency", firstWinCyc - firstAcceptCyc, 13);
    checkOutput("full_done_latency", doneCyc - firstAcceptCyc, 26);
    checkOutput("lit_count", logRow.size(), NWIN);
    for (int i = 0; i < NWIN && i < logRow.size(); i++) begin
      checkOutput("lit_row", logRow[i], litRow[i]);
      checkOutput("lit_col", logCol[i], litCol[i]);
    end

    applyStimulus(0, 1, 200);
    checkWindows("stall");

    applyStimulus(1, 0, 200);
    checkWindows("bubble");

    clearFrameStats();
    @(posedge clk) #1;
    start = 1'b1;
    @(posedge clk) #1;
    start = 1'b0;
    pixValid = 1'b1;
    n = 0;
    while (frameAccepts < 15 && n < 100) begin
      @(posedge clk) #1;
      n++;
    end
    checkOutput("midrst_reached", frameAccepts >= 15, 1);
    rst = 1'b1;
    @(posedge clk) #1;
    rst = 1'b0;
    pixValid = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midrst_no_done", doneCount, 0);
    checkOutput("midrst_idle", busy, 0);
    applyStimulus(0, 0, 200);
    checkWindows("after_rst");

    for (int f = 0; f < 4; f++) begin
      applyStimulus(2, 2, 600);
      checkWindows("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
